// File: rtl/fetch_pc_unit.sv
// Fetch and next-PC stage: holds the PC, decodes the controller selector fields,
// resolves branches and jumps, and implements syscall halt/resume with statistics counters.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          ADDR_W    = 10,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_rs_data,
    input  logic [31:0]       in_rt_data,
    input  logic [31:0]       in_v0,
    input  logic              in_syscall,
    input  logic              in_go,
    output logic [31:0]       out_pc,
    output logic [ADDR_W-1:0] out_imaddr,
    output logic [31:0]       out_instr,
    output logic              out_special,
    output logic [5:0]        out_func,
    output logic [31:0]       out_link_pc,
    output logic              out_run,
    output logic              out_halted,
    output logic [CNT_W-1:0]  out_cycles,
    output logic [CNT_W-1:0]  out_jumps,
    output logic [CNT_W-1:0]  out_btaken
);

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic [CNT_W-1:0]   jumps_q, jumps_d;
    logic [CNT_W-1:0]   btaken_q, btaken_d;

    logic [5:0]         opcode;
    logic               special;
    logic [31:0]        pc4, boff, jtgt, next_pc;
    logic               is_jr, is_j, is_jump, br_taken, halt_req;

    assign opcode  = in_instr[31:26];
    assign special = (opcode == 6'b000000);
    assign pc4     = pc_q + 32'd4;
    assign boff    = pc4 + {{14{in_instr[15]}}, in_instr[15:0], 2'b00};
    assign jtgt    = {pc4[31:28], in_instr[25:0], 2'b00};

    assign is_jr    = special && (in_instr[5:0] == 6'b001000);
    assign is_j     = (opcode == 6'b000010) || (opcode == 6'b000011);
    assign is_jump  = is_jr || is_j;
    assign halt_req = in_syscall && (in_v0 == HALT_CODE);

    always_comb begin
        br_taken = 1'b0;
        unique case (opcode)
            6'b000100: br_taken = (in_rs_data == in_rt_data);
            6'b000101: br_taken = (in_rs_data != in_rt_data);
            6'b000001: br_taken = (in_instr[20:16] == 5'b00001) && !in_rs_data[31];
            default:   br_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = pc4;
        if (is_jr)
            next_pc = in_rs_data;
        else if (is_j)
            next_pc = jtgt;
        else if (br_taken)
            next_pc = boff;
    end

    // A halting syscall steps to pc4 and is the last counted edge before HALT.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cycles_d = cycles_q;
        jumps_d  = jumps_q;
        btaken_d = btaken_q;
        unique case (state_q)
            ST_RUN: begin
                cycles_d = cycles_q + CNT_W'(1);
                if (halt_req) begin
                    pc_d    = pc4;
                    state_d = ST_HALT;
                end else begin
                    pc_d = next_pc;
                    if (is_jump)
                        jumps_d = jumps_q + CNT_W'(1);
                    if (br_taken)
                        btaken_d = btaken_q + CNT_W'(1);
                end
            end
            ST_HALT: begin
                if (in_go)
                    state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            cycles_q <= '0;
            jumps_q  <= '0;
            btaken_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            jumps_q  <= jumps_d;
            btaken_q <= btaken_d;
        end
    end

    assign out_pc      = pc_q;
    assign out_imaddr  = pc_q[ADDR_W+1:2];
    assign out_instr   = in_instr;
    assign out_special = special;
    assign out_func    = special ? in_instr[5:0] : opcode;
    assign out_link_pc = pc4;
    assign out_halted  = (state_q == ST_HALT);
    assign out_run     = (state_q == ST_RUN);
    assign out_cycles  = cycles_q;
    assign out_jumps   = jumps_q;
    assign out_btaken  = btaken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: stimulus pushes expectations, monitors pop and compare.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_instr = '0, in_rs_data = '0, in_rt_data = '0, in_v0 = '0;
    logic        in_syscall = 1'b0, in_go = 1'b0;
    logic [31:0] out_pc, out_instr, out_link_pc;
    logic [9:0]  out_imaddr;
    logic        out_special, out_run, out_halted;
    logic [5:0]  out_func;
    logic [31:0] out_cycles, out_jumps, out_btaken;

    int total = 0;
    int bad   = 0;

    fetch_pc_unit dut (
        .clk(clk), .rst(rst), .in_instr(in_instr), .in_rs_data(in_rs_data),
        .in_rt_data(in_rt_data), .in_v0(in_v0), .in_syscall(in_syscall), .in_go(in_go),
        .out_pc(out_pc), .out_imaddr(out_imaddr), .out_instr(out_instr),
        .out_special(out_special), .out_func(out_func), .out_link_pc(out_link_pc),
        .out_run(out_run), .out_halted(out_halted), .out_cycles(out_cycles),
        .out_jumps(out_jumps), .out_btaken(out_btaken)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        halted;
        logic [31:0] cycles, jumps, btaken;
    } st_exp_t;

    typedef struct {
        string       name;
        logic [31:0] link;
        logic        special;
        logic [5:0]  func;
    } cb_exp_t;

    st_exp_t st_q[$];
    cb_exp_t cb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // State monitor: samples just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                st_exp_t e;
                e = st_q.pop_front();
                chk({e.name, ".pc"},     out_pc,      e.pc);
                chk({e.name, ".imaddr"}, 32'(out_imaddr), 32'(e.pc[11:2]));
                chk({e.name, ".halted"}, 32'(out_halted), 32'(e.halted));
                chk({e.name, ".run"},    32'(out_run),    32'(!e.halted));
                chk({e.name, ".cycles"}, out_cycles,  e.cycles);
                chk({e.name, ".jumps"},  out_jumps,   e.jumps);
                chk({e.name, ".btaken"}, out_btaken,  e.btaken);
                $display("txn %s pc=%h halted=%0d cycles=%0d jumps=%0d btaken=%0d",
                         e.name, out_pc, out_halted, out_cycles, out_jumps, out_btaken);
            end
        end
    end

    // Decode monitor: samples on the falling edge, while inputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            if (cb_q.size() > 0) begin
                cb_exp_t c;
                c = cb_q.pop_front();
                chk({c.name, ".link"},    out_link_pc, c.link);
                chk({c.name, ".special"}, 32'(out_special), 32'(c.special));
                chk({c.name, ".func"},    32'(out_func),    32'(c.func));
                chk({c.name, ".instr"},   out_instr,   in_instr);
                $display("txn %s decode link=%h special=%0d func=%h",
                         c.name, out_link_pc, out_special, out_func);
            end
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] v0, input logic sc, input logic go);
        in_instr = instr; in_rs_data = rs; in_rt_data = rt;
        in_v0 = v0; in_syscall = sc; in_go = go;
    endtask

    task automatic dec(input string nm, input logic [31:0] link, input logic sp, input logic [5:0] fn);
        cb_exp_t c;
        c.name = nm; c.link = link; c.special = sp; c.func = fn;
        cb_q.push_back(c);
    endtask

    task automatic step(input string nm, input logic [31:0] pc, input logic h,
                        input logic [31:0] cy, input logic [31:0] jm, input logic [31:0] bt);
        st_exp_t e;
        e.name = nm; e.pc = pc; e.halted = h; e.cycles = cy; e.jumps = jm; e.btaken = bt;
        st_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;

    initial begin
        rst = 1'b1;
        drive(NOP, 0, 0, 0, 0, 0);
        step("reset", 32'h0, 0, 0, 0, 0);
        rst = 1'b0;

        drive(32'h2001_0005, 0, 0, 0, 0, 0); dec("addi", 32'h4, 0, 6'h08);
        step("addi", 32'h4, 0, 1, 0, 0);
        drive(32'h0022_1820, 0, 0, 0, 0, 0); dec("add", 32'h8, 1, 6'h20);
        step("add", 32'h8, 0, 2, 0, 0);
        drive(32'h0022_2025, 0, 0, 0, 0, 0); dec("or", 32'hC, 1, 6'h25);
        step("or", 32'hC, 0, 3, 0, 0);
        drive(NOP, 0, 0, 0, 0, 0);
        step("nop", 32'h10, 0, 4, 0, 0);

        drive(32'h1022_0003, 5, 5, 0, 0, 0); dec("beq_t", 32'h14, 0, 6'h04);
        step("beq_taken", 32'h20, 0, 5, 0, 1);
        drive(32'h1022_0003, 5, 6, 0, 0, 0);
        step("beq_not", 32'h24, 0, 6, 0, 1);
        drive(32'h0421_0004, 32'h8000_0000, 0, 0, 0, 0); dec("bgez", 32'h28, 0, 6'h01);
        step("bgez_neg", 32'h28, 0, 7, 0, 1);
        drive(32'h0421_0004, 32'h0, 0, 0, 0, 0);
        step("bgez_zero", 32'h3C, 0, 8, 0, 2);
        drive(32'h1422_0002, 1, 2, 0, 0, 0);
        step("bne_taken", 32'h48, 0, 9, 0, 3);
        drive(32'h1022_FFFE, 7, 7, 0, 0, 0);
        step("beq_back", 32'h44, 0, 10, 0, 4);

        drive(32'h0800_0040, 0, 0, 0, 0, 0); dec("j", 32'h48, 0, 6'h02);
        step("j", 32'h100, 0, 11, 1, 4);
        drive(32'h0C00_0003, 0, 0, 0, 0, 0); dec("jal", 32'h104, 0, 6'h03);
        step("jal", 32'hC, 0, 12, 2, 4);
        drive(32'h03E0_0008, 32'h24, 0, 0, 0, 0); dec("jr", 32'h10, 1, 6'h08);
        step("jr", 32'h24, 0, 13, 3, 4);
        drive(NOP, 0, 0, 0, 0, 0);
        step("nop", 32'h28, 0, 14, 3, 4);
        step("nop", 32'h2C, 0, 15, 3, 4);
        step("nop", 32'h30, 0, 16, 3, 4);

        drive(SYSCALL, 0, 0, 32'd10, 1, 0); dec("sys", 32'h34, 1, 6'h0C);
        step("syscall_halt", 32'h34, 1, 17, 3, 4);
        for (int i = 0; i < 5; i++)
            step("idle", 32'h34, 1, 17, 3, 4);
        drive(NOP, 0, 0, 0, 0, 1);
        step("go", 32'h34, 0, 17, 3, 4);
        drive(NOP, 0, 0, 0, 0, 0);
        step("resume", 32'h38, 0, 18, 3, 4);
        drive(SYSCALL, 0, 0, 32'd1, 1, 0);
        step("syscall_v0_1", 32'h3C, 0, 19, 3, 4);
        drive(NOP, 0, 0, 0, 0, 1);
        step("go_in_run", 32'h40, 0, 20, 3, 4);
        drive(SYSCALL, 0, 0, 32'd10, 1, 1);
        step("halt_with_go", 32'h44, 1, 21, 3, 4);
        drive(32'h03E0_0008, 32'h80, 0, 0, 0, 0);
        step("halt_holds_jr", 32'h44, 1, 21, 3, 4);

        rst = 1'b1;
        step("reset_halted", 32'h0, 0, 0, 0, 0);
        rst = 1'b0;

        force dut.cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycles_q;
        drive(NOP, 0, 0, 0, 0, 0);
        step("cycles_wrap", 32'h4, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("queues_drained", 32'(st_q.size() + cb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
